stopwatch_timer: RTL

STOPWATCH_TIMER -- requirements
Module: stopwatch_timer

---
 rtl/stopwatch_timer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stopwatch_timer : sec:ms stopwatch / countdown with lap capture  (rev 1.0)
// ---------------------------------------------------------------------------
module stopwatch_timer #(
   parameter int TICK_DIV = 50000,
   parameter int MS_MAX   = 999,
   parameter int SEC_MAX  = 99,
   parameter int W_MS     = 10,
   parameter int W_SEC    = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             clear_i,
   input  logic             lap_i,
   input  logic             mode_i,
   input  logic             load_i,
   input  logic [W_SEC-1:0] load_sec_i,
   output logic [W_MS-1:0]  ms_o,
   output logic [W_SEC-1:0] sec_o,
   output logic [W_MS-1:0]  lap_ms_o,
   output logic [W_SEC-1:0] lap_sec_o,
   output logic             lap_valid_o,
   output logic             running_o,
   output logic             wrap_o,
   output logic             done_o
);

   localparam int               c_W_PRE    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_W_PRE-1:0] c_PRE_LAST = c_W_PRE'(TICK_DIV - 1);
   localparam logic [W_MS-1:0]  c_MS_MAX   = W_MS'(MS_MAX);
   localparam logic [W_SEC-1:0] c_SEC_MAX  = W_SEC'(SEC_MAX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [W_MS-1:0]    ms_q, ms_d, lap_ms_q, lap_ms_d;
   logic [W_SEC-1:0]   sec_q, sec_d, lap_sec_q, lap_sec_d;
   logic [c_W_PRE-1:0] pre_q, pre_d;
   logic               mode_q, mode_d;
   logic               lap_valid_q, lap_valid_d;
   logic               running_q, running_d;
   logic               wrap_q, wrap_d;
   logic               done_q, done_d;
   logic               w_tick;

   assign w_tick = (pre_q == c_PRE_LAST);

   always_comb begin
      state_d     = state_q;
      ms_d        = ms_q;
      sec_d       = sec_q;
      pre_d       = pre_q;
      mode_d      = mode_q;
      lap_ms_d    = lap_ms_q;
      lap_sec_d   = lap_sec_q;
      lap_valid_d = 1'b0;
      wrap_d      = 1'b0;
      done_d      = 1'b0;

      if (clear_i) begin
         state_d = S_IDLE;
         ms_d    = '0;
         sec_d   = '0;
         pre_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (load_i) begin
                  ms_d  = '0;
                  sec_d = (load_sec_i > c_SEC_MAX) ? c_SEC_MAX : load_sec_i;
               end else if (start_i && !stop_i) begin
                  mode_d = mode_i;
                  pre_d  = '0;
                  if (mode_i && ms_q == '0 && sec_q == '0) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_RUN;
                  end
               end
            end
            S_RUN: begin
               pre_d = w_tick ? '0 : pre_q + c_W_PRE'(1);
               if (w_tick) begin
                  if (!mode_q) begin
                     if (ms_q != c_MS_MAX) begin
                        ms_d = ms_q + W_MS'(1);
                     end else begin
                        ms_d = '0;
                        if (sec_q != c_SEC_MAX) begin
                           sec_d = sec_q + W_SEC'(1);
                        end else begin
                           sec_d  = '0;
                           wrap_d = 1'b1;
                        end
                     end
                  end else if (sec_q == '0 && ms_q <= W_MS'(1)) begin
                     // Last countdown tick: lands on 0:000 and finishes.
                     ms_d   = '0;
                     done_d = 1'b1;
                  end else if (ms_q != '0) begin
                     ms_d = ms_q - W_MS'(1);
                  end else begin
                     ms_d  = c_MS_MAX;
                     sec_d = sec_q - W_SEC'(1);
                  end
               end
               if (done_d) begin
                  state_d = S_DONE;
               end else if (stop_i) begin
                  state_d = S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (!stop_i && start_i) begin
                  state_d = S_RUN;
               end
            end
            default: begin
               ms_d  = '0;
               sec_d = '0;
            end
         endcase

         if (lap_i && (state_q == S_RUN || state_q == S_PAUSE)) begin
            lap_ms_d    = ms_q;
            lap_sec_d   = sec_q;
            lap_valid_d = 1'b1;
         end
      end

      running_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ms_q        <= '0;
         sec_q       <= '0;
         pre_q       <= '0;
         mode_q      <= 1'b0;
         lap_ms_q    <= '0;
         lap_sec_q   <= '0;
         lap_valid_q <= 1'b0;
         running_q   <= 1'b0;
         wrap_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ms_q        <= ms_d;
         sec_q       <= sec_d;
         pre_q       <= pre_d;
         mode_q      <= mode_d;
         lap_ms_q    <= lap_ms_d;
         lap_sec_q   <= lap_sec_d;
         lap_valid_q <= lap_valid_d;
         running_q   <= running_d;
         wrap_q      <= wrap_d;
         done_q      <= done_d;
      end
   end

   assign ms_o        = ms_q;
   assign sec_o       = sec_q;
   assign lap_ms_o    = lap_ms_q;
   assign lap_sec_o   = lap_sec_q;
   assign lap_valid_o = lap_valid_q;
   assign running_o   = running_q;
   assign wrap_o      = wrap_q;
   assign done_o      = done_q;

endmodule
`default_nettype wire
